pixel_commit: RTL and testbench



---
 rtl/pixel_pkg.sv | 41 ++++
 rtl/pixel_fifo.sv | 54 +++++
 rtl/pixel_commit.sv | 172 +++++++++++++++++
 tb/tb_pixel_commit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module : pixel_pkg
// Purpose: Shared constants, types and helpers for the pixel commit block.
//          Screen geometry, framebuffer size, FSM state encoding, plot
//          request record and the (x,y) -> linear address conversion.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int FB_SIZE  = SCREEN_W * SCREEN_H;  // 19200

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

  // y*160 + x, built from shifts so no multiplier is needed:
  // y*160 = y*128 + y*32.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module : pixel_fifo
// Purpose: Small synchronous FIFO holding plot requests {x,y,colour}.
//          Read data is the current head (first-word fall-through), so a
//          push into a full FIFO is safe when a pop happens in the same cycle.
// Ports  : clk_i, rst_i     clock / synchronous active-high reset
//          push_i, data_i   write side
//          pop_i, data_o    read side (data_o valid while !empty_o)
//          full_o, empty_o  status
// Rev    : 1.0  initial release
// ============================================================================
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[PTR_W-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[PTR_W-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/pixel_commit.sv
`default_nettype none
// ============================================================================
// Module : pixel_commit
// Purpose: Receives sprite plot requests, clips them to the screen, buffers
//          them, converts (x,y) to a linear address and commits them to the
//          framebuffer write port (valid/ready). Also walks the whole screen
//          for a background fill.
// Ports  : clock_i, reset_i             clock / synchronous active-high reset
//          x_i, y_i, colour_i, plot_i   plot request
//          fill_i, fill_colour_i        fill walk start / colour
//          mem_addr_o, mem_data_o,
//          mem_we_o, mem_ready_i        framebuffer write handshake
//          busy_o, fill_done_o,
//          overflow_o, clip_count_o     status
// Rev    : 1.0  initial release
// ============================================================================
module pixel_commit #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  x_i,
  input  logic [6:0]  y_i,
  input  logic [2:0]  colour_i,
  input  logic        plot_i,
  input  logic        fill_i,
  input  logic [2:0]  fill_colour_i,
  output logic [14:0] mem_addr_o,
  output logic [2:0]  mem_data_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        fill_done_o,
  output logic        overflow_o,
  output logic [7:0]  clip_count_o
);

  import pixel_pkg::*;

  localparam logic [ADDR_W-1:0] FILL_END = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_SIZE - 1);

  // Request capture register: requests are sampled on the edge, then
  // clipped / pushed on the following cycle.
  plot_t                in_q;
  logic                 in_vld_q;

  plot_t                fifo_rd;
  logic                 fifo_full, fifo_empty;

  state_e               state_q;
  logic [ADDR_W-1:0]    fill_cnt_q;   // next fill address to issue
  logic [COLOUR_W-1:0]  fill_col_q;
  logic                 fill_done_q;
  logic                 overflow_q;
  logic [7:0]           clip_cnt_q;

  logic                 out_vld_q, out_vld_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [COLOUR_W-1:0]  out_data_q, out_data_d;

  logic w_in_range, w_clip, w_want_push, w_push, w_drop, w_pop;
  logic w_xfer, w_slot_free, w_fill_start, w_fill_issue, w_fill_last;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      in_q     <= '0;
      in_vld_q <= 1'b0;
    end else begin
      in_q     <= '{x: x_i, y: y_i, colour: colour_i};
      in_vld_q <= plot_i;
    end
  end

  assign w_in_range  = (int'(in_q.x) < SCREEN_W) && (int'(in_q.y) < SCREEN_H);
  assign w_clip      = in_vld_q && !w_in_range;
  assign w_want_push = in_vld_q && w_in_range;

  assign w_xfer      = out_vld_q && mem_ready_i;
  assign w_slot_free = !out_vld_q || w_xfer;

  // A fill start takes the empty output stage this cycle, so no pop then.
  assign w_fill_start = (state_q == ST_RUN) && fill_i && !out_vld_q;
  assign w_pop        = (state_q == ST_RUN) && !w_fill_start && w_slot_free && !fifo_empty;
  assign w_push       = w_want_push && (!fifo_full || w_pop);
  assign w_drop       = w_want_push && !w_push;

  assign w_fill_issue = (state_q == ST_FILL) && w_slot_free && (fill_cnt_q != FILL_END);
  assign w_fill_last  = (state_q == ST_FILL) && w_xfer && (out_addr_q == FILL_LAST);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(plot_t))
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (w_push),
    .data_i  (in_q),
    .pop_i   (w_pop),
    .data_o  (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output stage next-state: holds while a transfer is pending.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    if (w_pop) begin
      out_vld_d  = 1'b1;
      out_addr_d = lin_addr(fifo_rd.x, fifo_rd.y);
      out_data_d = fifo_rd.colour;
    end else if (w_fill_issue) begin
      out_vld_d  = 1'b1;
      out_addr_d = fill_cnt_q;
      out_data_d = fill_col_q;
    end else if (w_xfer) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      fill_cnt_q  <= '0;
      fill_col_q  <= '0;
      fill_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      clip_cnt_q  <= '0;
      out_vld_q   <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      fill_done_q <= 1'b0;
      if (w_drop) overflow_q <= 1'b1;
      if (w_clip && (clip_cnt_q != 8'hFF)) clip_cnt_q <= clip_cnt_q + 8'd1;
      case (state_q)
        ST_RUN: begin
          if (w_fill_start) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            fill_col_q <= fill_colour_i;
          end
        end
        ST_FILL: begin
          if (w_fill_issue) fill_cnt_q <= fill_cnt_q + 1'b1;
          if (w_fill_last) begin
            state_q     <= ST_RUN;
            fill_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign mem_addr_o   = out_addr_q;
  assign mem_data_o   = out_data_q;
  assign mem_we_o     = out_vld_q;
  assign busy_o       = !fifo_empty || out_vld_q || (state_q == ST_FILL);
  assign fill_done_o  = fill_done_q;
  assign overflow_o   = overflow_q;
  assign clip_count_o = clip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_commit.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_commit
// Purpose: Self-checking bench for pixel_commit. Expected framebuffer
//          writes are kept as an ordered list of (addr,data) built from the
//          plots and fills the bench issues; observed writes are collected
//          by a handshake monitor and compared against it.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_commit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        plot = 1'b0;
  logic        fill = 1'b0;
  logic [2:0]  fill_colour = '0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        fill_done;
  logic        overflow;
  logic [7:0]  clip_count;

  int n_cmp = 0;
  int n_err = 0;

  int got_a[$], got_d[$], exp_a[$], exp_d[$];
  int wr_n = 0;
  int done_cnt = 0;
  int done_at = -1;

  pixel_commit dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .x_i           (x),
    .y_i           (y),
    .colour_i      (colour),
    .plot_i        (plot),
    .fill_i        (fill),
    .fill_colour_i (fill_colour),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_we_o      (mem_we),
    .mem_ready_i   (mem_ready),
    .busy_o        (busy),
    .fill_done_o   (fill_done),
    .overflow_o    (overflow),
    .clip_count_o  (clip_count)
  );

  always #5 clock = ~clock;

  // Handshake monitor: sees pre-edge values of outputs and inputs.
  always @(posedge clock) begin
    if (fill_done) begin
      done_cnt = done_cnt + 1;
      done_at  = wr_n;
    end
    if (mem_we && mem_ready) begin
      got_a.push_back(int'(mem_addr));
      got_d.push_back(int'(mem_data));
      wr_n = wr_n + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    wr_n = 0; done_cnt = 0; done_at = -1;
  endtask

  task automatic do_reset();
    plot = 1'b0; fill = 1'b0; mem_ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    clear_log();
    step();
  endtask

  // Reference model of the address mapping: row-major, 160 pixels per row.
  function automatic int ref_addr(input int xx, input int yy);
    return yy * 160 + xx;
  endfunction

  task automatic drive_plot(input int xx, input int yy, input int cc);
    x = 8'(xx); y = 7'(yy); colour = 3'(cc); plot = 1'b1;
    if (xx < 160 && yy < 120) begin
      exp_a.push_back(ref_addr(xx, yy));
      exp_d.push_back(cc);
    end
  endtask

  // Compare the observed write stream with the expected one.
  task automatic check_stream(input string tag);
    int bad;
    bad = -1;
    check({tag, "_count"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      if (bad < 0 && (got_a[i] != exp_a[i] || got_d[i] != exp_d[i])) bad = i;
    end
    check({tag, "_first_bad_idx"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  initial begin
    int saved_a, saved_d, clip_exp, dc;

    // ---------------- reset state
    do_reset();
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fill_done", 32'(fill_done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_clip", 32'(clip_count), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);

    // ---------------- single plot latency
    drive_plot(20, 75, 6);
    step(); plot = 1'b0;
    check("lat_we_k", 32'(mem_we), 0);
    step();
    check("lat_we_k1", 32'(mem_we), 0);
    step();
    check("lat_we_k2", 32'(mem_we), 1);
    check("lat_addr", 32'(mem_addr), 12020);
    check("lat_data", 32'(mem_data), 6);
    step();
    check("lat_we_after", 32'(mem_we), 0);
    check_stream("lat");

    // ---------------- clipping
    do_reset();
    drive_plot(160, 10, 1); step();
    drive_plot(5, 120, 2);  step();
    plot = 1'b0;
    repeat (4) step();
    check("clip_writes", 32'(wr_n), 0);
    check("clip_count2", 32'(clip_count), 2);
    for (int i = 0; i < 298; i++) begin
      drive_plot(160 + (i % 96), i % 128, i % 8); step();
    end
    plot = 1'b0;
    repeat (4) step();
    check("clip_sat", 32'(clip_count), 255);
    check("clip_writes2", 32'(wr_n), 0);

    // ---------------- stall and overflow
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_plot(10 + i, 3 + i, i + 1); step();
    end
    plot = 1'b0;
    void'(exp_a.pop_back()); void'(exp_d.pop_back());  // 6th plot is dropped
    repeat (3) step();
    check("stall_overflow", 32'(overflow), 1);
    check("stall_we", 32'(mem_we), 1);
    check("stall_busy", 32'(busy), 1);
    check("stall_addr", 32'(mem_addr), 32'(ref_addr(10, 3)));
    saved_a = int'(mem_addr); saved_d = int'(mem_data);
    repeat (3) step();
    check("stall_addr_hold", 32'(mem_addr), 32'(saved_a));
    check("stall_data_hold", 32'(mem_data), 32'(saved_d));
    check("stall_no_write", 32'(wr_n), 0);
    mem_ready = 1'b1;
    repeat (10) step();
    check_stream("stall");
    check("stall_idle", 32'(busy), 0);

    // ---------------- full fill walk with plots arriving mid-walk
    do_reset();
    for (int a = 0; a < 19200; a++) begin
      exp_a.push_back(a); exp_d.push_back(0);
    end
    fill_colour = 3'd0; fill = 1'b1;
    step(); fill = 1'b0;
    repeat (10) step();
    drive_plot(1, 2, 3);     step();
    drive_plot(159, 119, 7); step();
    drive_plot(0, 0, 4);     step();
    plot = 1'b0;
    for (int c = 0; c < 21000 && done_cnt == 0; c++) step();
    check("fill_done_seen", 32'(done_cnt), 1);
    repeat (10) step();
    check("fill_done_once", 32'(done_cnt), 1);
    check("fill_done_at", 32'(done_at), 19200);
    check_stream("fill");

    // ---------------- mem_ready toggling each cycle, plots every other cycle
    do_reset();
    for (int i = 0; i < 32; i++) begin
      mem_ready = i[0];
      if (!i[0]) drive_plot(7 * (i / 2), 119 - i / 2, (i / 2) % 8);
      else plot = 1'b0;
      step();
    end
    plot = 1'b0; mem_ready = 1'b1;
    repeat (10) step();
    check_stream("toggle");
    check("toggle_overflow", 32'(overflow), 0);

    // ---------------- randomized traffic against the ordered-list model
    do_reset();
    clip_exp = 0;
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      // Keep outstanding accepted plots within capacity so none is dropped.
      if ($urandom_range(0, 1) == 1 && (exp_a.size() - wr_n) < 4) begin
        int xx, yy;
        xx = $urandom_range(0, 175);
        yy = $urandom_range(0, 127);
        if (!(xx < 160 && yy < 120)) clip_exp++;
        drive_plot(xx, yy, $urandom_range(0, 7));
      end else begin
        plot = 1'b0;
      end
      step();
    end
    plot = 1'b0; mem_ready = 1'b1;
    repeat (12) step();
    check_stream("rand");
    check("rand_clip", 32'(clip_count), 32'(clip_exp > 255 ? 255 : clip_exp));
    check("rand_overflow", 32'(overflow), 0);
    check("rand_idle", 32'(busy), 0);

    // ---------------- reset in the middle of a fill
    do_reset();
    fill_colour = 3'd5; fill = 1'b1;
    step(); fill = 1'b0;
    for (int c = 0; c < 1000 && !(mem_we && mem_addr == 15'd500); c++) step();
    check("midfill_addr", 32'(mem_addr), 500);
    check("midfill_data", 32'(mem_data), 5);
    dc = done_cnt;
    reset = 1'b1;
    step();
    check("midfill_rst_we", 32'(mem_we), 0);
    check("midfill_rst_busy", 32'(busy), 0);
    check("midfill_rst_done", 32'(fill_done), 0);
    reset = 1'b0;
    repeat (5) step();
    check("midfill_post_we", 32'(mem_we), 0);
    check("midfill_no_done", 32'(done_cnt), 32'(dc));
    // Back in RUN: a plot takes the normal path.
    x = 8'd1; y = 7'd1; colour = 3'd2; plot = 1'b1;
    step(); plot = 1'b0;
    step(); step();
    check("midfill_run_we", 32'(mem_we), 1);
    check("midfill_run_addr", 32'(mem_addr), 161);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
